apb_slave_mem: RTL and testbench

- APB slave memory: the target that the APB driver/monitor interface signals connect to.
- Word-addressed register memory with a fixed, parameterised wait-state count.
- Flags errors on misaligned and out-of-range accesses.
- Serves as the DUT for the APB environment. It consumes paddr/pwdata/pwrite/pselx/penable and produces prdata/pready/pslave_error.

---
 rtl/apb_slave_mem.sv | 112 +++++++++++
 tb/tb_apb_slave_mem.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/apb_slave_mem.sv
// APB slave backed by a word-addressed register memory with a fixed wait-state count.
// Misaligned or out-of-range accesses complete with pslave_error and leave memory untouched.
module apb_slave_mem #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  input  logic                  pwrite,
  input  logic                  pselx,
  input  logic                  penable,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslave_error
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH-3:0] DEPTH_W = (ADDR_WIDTH-2)'(MEM_DEPTH);
  localparam logic [3:0] WAIT_W = 4'(WAIT_STATES);

  typedef enum logic [0:0] {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t                  state_r, state_s;
  logic [3:0]              cnt_r;
  logic [IDX_W-1:0]        addr_r;
  logic [DATA_WIDTH-1:0]   wdata_r;
  logic                    write_r;
  logic                    err_r;
  logic [DATA_WIDTH-1:0]   prdata_r;
  logic                    setup_s;
  logic                    complete_s;
  logic                    pready_s;
  logic                    err_s;
  logic [IDX_W-1:0]        idx_s;
  logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

  assign idx_s    = paddr[IDX_W+1:2];
  assign err_s    = (paddr[1:0] != 2'b00) | (paddr[ADDR_WIDTH-1:2] >= DEPTH_W);
  // Gating with presetn keeps the response quiet for the whole time reset is held.
  assign pready_s = presetn & (state_r == ACCESS) & (cnt_r == 4'd0);

  // Next-state decode and setup/completion strobes.
  always_comb begin
    state_s    = state_r;
    setup_s    = 1'b0;
    complete_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (pselx && !penable) begin
          state_s = ACCESS;
          setup_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      ACCESS: begin
        if (!pselx) begin
          state_s = IDLE;
        end else if (penable && pready_s) begin
          state_s    = IDLE;
          complete_s = 1'b1;
        end else begin
          state_s = ACCESS;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State, wait counter, latched transfer and read-data registers.
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state_r  <= IDLE;
      cnt_r    <= 4'd0;
      addr_r   <= '0;
      wdata_r  <= '0;
      write_r  <= 1'b0;
      err_r    <= 1'b0;
      prdata_r <= '0;
    end else begin
      state_r <= state_s;
      if (setup_s) begin
        addr_r  <= idx_s;
        wdata_r <= pwdata;
        write_r <= pwrite;
        err_r   <= err_s;
        cnt_r   <= WAIT_W;
        if (!pwrite) begin
          prdata_r <= err_s ? '0 : mem[idx_s];
        end
      end else if ((state_r == ACCESS) && pselx && penable && (cnt_r != 4'd0)) begin
        cnt_r <= cnt_r - 4'd1;
      end
    end
  end

  // Memory write on a clean write completion; the array itself is never reset.
  always_ff @(posedge pclk) begin
    if (presetn && complete_s && write_r && !err_r) begin
      mem[addr_r] <= wdata_r;
    end
  end

  assign prdata       = prdata_r;
  assign pready       = pready_s;
  assign pslave_error = pready_s & err_r;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Scoreboard bench for apb_slave_mem: one instance with two wait states, one with none.
module tb_apb_slave_mem;

  logic        pclk = 1'b0;
  logic        presetn;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic        pwrite;
  logic        penable;
  logic        sel2, sel0;
  logic [31:0] rd2, rd0;
  logic        rdy2, rdy0;
  logic        err2, err0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        wr;
    logic [31:0] data;
    logic        err;
  } exp_t;
  exp_t sb[$];

  always #5 pclk = ~pclk;

  apb_slave_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(2)) u_dut2 (
    .pclk(pclk), .presetn(presetn), .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite),
    .pselx(sel2), .penable(penable), .prdata(rd2), .pready(rdy2), .pslave_error(err2)
  );

  apb_slave_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(0)) u_dut0 (
    .pclk(pclk), .presetn(presetn), .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite),
    .pselx(sel0), .penable(penable), .prdata(rd0), .pready(rdy0), .pslave_error(err0)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // One complete transfer; expectation queued at issue, compared when pready is seen.
  task automatic apb_xfer(input bit on0, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_data,
                          input bit exp_err);
    exp_t e;
    int   waits;
    int   ws;
    e.wr = wr; e.data = exp_data; e.err = exp_err;
    sb.push_back(e);
    ws = on0 ? 0 : 2;
    @(negedge pclk);
    sel0 = on0; sel2 = !on0; penable = 1'b0;
    pwrite = wr; paddr = addr; pwdata = wdata;
    @(negedge pclk);
    penable = 1'b1;
    waits = 0;
    while (!(on0 ? rdy0 : rdy2) && waits < 20) begin
      @(negedge pclk);
      waits++;
    end
    check_eq("latency", 32'(waits), 32'(ws));
    e = sb.pop_front();
    check_eq("pslverr", 32'(on0 ? err0 : err2), 32'(e.err));
    if (!e.wr) check_eq("prdata", on0 ? rd0 : rd2, e.data);
    @(posedge pclk);
  endtask

  task automatic go_idle();
    @(negedge pclk);
    sel0 = 1'b0; sel2 = 1'b0; penable = 1'b0;
  endtask

  initial begin
    presetn = 1'b0; sel2 = 1'b1; sel0 = 1'b1; penable = 1'b1;
    pwrite = 1'b1; paddr = 32'h0; pwdata = 32'hFFFF_FFFF;

    // Reset held with a bogus access on the bus.
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      check_eq("rst_pready2", 32'(rdy2), 32'd0);
      check_eq("rst_err2", 32'(err2), 32'd0);
      check_eq("rst_prdata2", rd2, 32'h0);
      check_eq("rst_pready0", 32'(rdy0), 32'd0);
      check_eq("rst_prdata0", rd0, 32'h0);
    end
    presetn = 1'b1; sel2 = 1'b0; sel0 = 1'b0; penable = 1'b0;
    @(negedge pclk);
    check_eq("post_rst_pready2", 32'(rdy2), 32'd0);

    // Two wait states: write then read back.
    apb_xfer(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0);
    apb_xfer(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);
    check_eq("prdata_hold", rd2, 32'hDEAD_BEEF);

    // Out of range, with word 0 holding a known value.
    apb_xfer(1'b0, 1'b1, 32'h0, 32'hCAFE_F00D, 32'h0, 1'b0);
    apb_xfer(1'b0, 1'b1, 32'h400, 32'h1234_5678, 32'h0, 1'b1);
    apb_xfer(1'b0, 1'b0, 32'h400, 32'h0, 32'h0, 1'b1);
    apb_xfer(1'b0, 1'b0, 32'h0, 32'h0, 32'hCAFE_F00D, 1'b0);
    apb_xfer(1'b0, 1'b1, 32'h3FC, 32'h0BAD_0001, 32'h0, 1'b0);
    apb_xfer(1'b0, 1'b0, 32'h3FC, 32'h0, 32'h0BAD_0001, 1'b0);

    // Misaligned write must not touch word 4.
    apb_xfer(1'b0, 1'b1, 32'h13, 32'h5A5A_5A5A, 32'h0, 1'b1);
    apb_xfer(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);
    go_idle();

    // Zero wait states, back to back.
    apb_xfer(1'b1, 1'b1, 32'h0, 32'h1, 32'h0, 1'b0);
    apb_xfer(1'b1, 1'b1, 32'h4, 32'h2, 32'h0, 1'b0);
    apb_xfer(1'b1, 1'b1, 32'h8, 32'h3, 32'h0, 1'b0);
    apb_xfer(1'b1, 1'b0, 32'h0, 32'h0, 32'h1, 1'b0);
    apb_xfer(1'b1, 1'b0, 32'h4, 32'h0, 32'h2, 1'b0);
    apb_xfer(1'b1, 1'b0, 32'h8, 32'h0, 32'h3, 1'b0);
    go_idle();

    // Abort: pselx dropped during a wait state.
    apb_xfer(1'b0, 1'b1, 32'h20, 32'h5555, 32'h0, 1'b0);
    @(negedge pclk);
    sel2 = 1'b1; sel0 = 1'b0; penable = 1'b0; pwrite = 1'b1; paddr = 32'h20; pwdata = 32'hAAAA;
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    check_eq("abort_wait_pready", 32'(rdy2), 32'd0);
    sel2 = 1'b0;
    apb_xfer(1'b0, 1'b0, 32'h20, 32'h0, 32'h5555, 1'b0);

    // Reset in the middle of an access.
    @(negedge pclk);
    sel2 = 1'b1; sel0 = 1'b0; penable = 1'b0; pwrite = 1'b1; paddr = 32'h20; pwdata = 32'hBBBB;
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    presetn = 1'b0;
    @(negedge pclk);
    check_eq("midrst_pready", 32'(rdy2), 32'd0);
    check_eq("midrst_prdata", rd2, 32'h0);
    presetn = 1'b1; sel2 = 1'b0; penable = 1'b0;
    apb_xfer(1'b0, 1'b0, 32'h20, 32'h0, 32'h5555, 1'b0);
    go_idle();

    check_eq("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
